// File: rtl/ads1115_sample_filter.sv
// ads1115_sample_filter
// Conditions the 16-bit ADS1115 conversion result: samples it on a fixed
// divider tick, clamps negative codes to zero, keeps a sliding-window average
// over 2^AVG_LOG2 samples and drives a hysteresis level flag from that average.
module ads1115_sample_filter #(
    parameter int          SAMPLE_DIV = 50000,
    parameter int          AVG_LOG2   = 3,
    parameter logic [15:0] TH_HIGH    = 16'd12000,
    parameter logic [15:0] TH_LOW     = 16'd8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sample_in,
    input  logic        clear,
    output logic [15:0] avg_out,
    output logic        avg_valid,
    output logic        level,
    output logic        level_change,
    output logic        warm
);

    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int DIV_W  = $clog2(SAMPLE_DIV);

    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_ONE   = DIV_W'(1);
    localparam logic [AVG_LOG2-1:0] PTR_ONE   = AVG_LOG2'(1);
    localparam logic [AVG_LOG2-1:0] FILL_LAST = AVG_LOG2'(DEPTH - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Negative two's-complement codes carry no useful level information.
    function automatic logic [DATA_W-1:0] clamp_neg(input logic signed [DATA_W-1:0] x);
        if (x < 0) begin
            return '0;
        end else begin
            return $unsigned(x);
        end
    endfunction

    // Window average by truncating division; the shifted sum always fits DATA_W.
    function automatic logic [DATA_W-1:0] window_avg(input logic [SUM_W-1:0] s);
        return DATA_W'(s >> AVG_LOG2);
    endfunction

    // Divider and tick
    logic [DIV_W-1:0]    div_q;
    logic                tick_q;

    // Stage 1: captured, clamped sample
    logic [DATA_W-1:0]   smp_p1_q;
    logic                vld_p1_q;

    // Stage 2: window accumulator
    logic [DATA_W-1:0]   win_q [DEPTH];
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_d;
    logic [AVG_LOG2-1:0] wptr_q;
    logic [AVG_LOG2-1:0] fill_q;
    logic [0:0]          state_q;
    logic [0:0]          state_d;
    logic [DATA_W-1:0]   oldest;
    logic                fill_done;

    // Stage 3: registered outputs
    logic [DATA_W-1:0]   avg_q;
    logic [DATA_W-1:0]   avg_d;
    logic                vld_p2_q;
    logic                vld_p2_d;
    logic                level_q;
    logic                level_d;
    logic                lchg_q;

    // Free-running sample divider; clear restarts the sampling phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else if (clear) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (div_q == DIV_LAST);
            div_q  <= (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
        end
    end

    // ---- stage 1: sample capture ----
    // Valid flag of the captured sample; a tick coinciding with clear is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= tick_q && !clear;
        end
    end

    // Sample and window storage carry no reset; their validity is tracked separately.
    always_ff @(posedge clk) begin
        if (tick_q) begin
            smp_p1_q <= clamp_neg($signed(sample_in));
        end
        if (vld_p1_q && !clear) begin
            win_q[wptr_q] <= smp_p1_q;
        end
    end

    // ---- stage 2: running sum, fill tracking, next outputs ----
    // Running sum update, fill completion and the hysteresis decision.
    always_comb begin
        oldest    = '0;
        if (state_q == ST_RUN) begin
            oldest = win_q[wptr_q];
        end
        sum_d     = sum_q + SUM_W'(smp_p1_q) - SUM_W'(oldest);
        fill_done = (state_q == ST_FILL) && (fill_q == FILL_LAST);
        vld_p2_d  = vld_p1_q && !clear && ((state_q == ST_RUN) || fill_done);
        avg_d     = window_avg(sum_d);

        level_d = level_q;
        if (vld_p2_d) begin
            if (!level_q && (avg_d >= TH_HIGH)) begin
                level_d = 1'b1;
            end else if (level_q && (avg_d <= TH_LOW)) begin
                level_d = 1'b0;
            end
        end

        state_d = state_q;
        if (clear) begin
            state_d = ST_FILL;
        end else if (vld_p1_q && fill_done) begin
            state_d = ST_RUN;
        end
    end

    // Accumulator, write pointer, fill counter and FILL/RUN state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            wptr_q  <= '0;
            fill_q  <= '0;
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
            if (clear) begin
                sum_q  <= '0;
                wptr_q <= '0;
                fill_q <= '0;
            end else if (vld_p1_q) begin
                sum_q  <= sum_d;
                wptr_q <= wptr_q + PTR_ONE;
                if (state_q == ST_FILL) begin
                    fill_q <= fill_q + PTR_ONE;
                end
            end
        end
    end

    // ---- stage 3: average, level and pulses ----
    // Average and level only move on a valid result; clear leaves them held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_q    <= '0;
            vld_p2_q <= 1'b0;
            level_q  <= 1'b0;
            lchg_q   <= 1'b0;
        end else begin
            vld_p2_q <= vld_p2_d;
            lchg_q   <= vld_p2_d && (level_d != level_q);
            if (vld_p2_d) begin
                avg_q   <= avg_d;
                level_q <= level_d;
            end
        end
    end

    assign avg_out      = avg_q;
    assign avg_valid    = vld_p2_q;
    assign level        = level_q;
    assign level_change = lchg_q;
    assign warm         = (state_q == ST_RUN);

endmodule
